id2exe_hazard_ctrl: RTL and testbench

- Pipeline control for the ID->EXE pipeline register and the stages ahead of it.
- Detects RAW hazards between the ID-stage sources and the EXE/MEM destinations, and applies branch flushes from EXE.
- Sequences multi-cycle data-memory waits with a WAIT state, a per-access cycle counter and a timeout.
- Drives freeze/flush strobes into the PC, IF->ID, ID->EXE and EXE->MEM registers, and keeps a saturating bubble counter for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 11 +
 rtl/hazard_detect.sv | 38 +++
 rtl/id2exe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_id2exe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: controller state encoding and register-index width.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW-hazard term for the ID-stage sources against the EXE/MEM destinations.
// FORWARDING_EN narrows the check to EXE load-use, since forwarding covers the other matches.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 idValid,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 twoSrc,
    input  logic [REG_IDX_W-1:0] exeDest,
    input  logic                 exeWbEn,
    input  logic                 exeMemRead,
    input  logic [REG_IDX_W-1:0] memDest,
    input  logic                 memWbEn,
    output logic                 hazard
);

    logic m1;
    logic m2;

`ifdef FORWARDING_EN
    assign m1 = (src1 == exeDest) & exeWbEn & exeMemRead;
    assign m2 = (src2 == exeDest) & exeWbEn & exeMemRead;

    logic unusedMemFields;
    assign unusedMemFields = ^{memDest, memWbEn};
`else
    assign m1 = ((src1 == exeDest) & exeWbEn) | ((src1 == memDest) & memWbEn);
    assign m2 = ((src2 == exeDest) & exeWbEn) | ((src2 == memDest) & memWbEn);

    logic unusedLoadFlag;
    assign unusedLoadFlag = exeMemRead;
`endif

    // R0 is deliberately not excluded: it is an ordinary destination here.
    assign hazard = idValid & (m1 | (twoSrc & m2));

endmodule

// File: rtl/id2exe_hazard_ctrl.sv
// ID->EXE pipeline control: same-cycle freeze/flush strobes, memory-wait FSM with timeout, bubble counter.
// Strobes are combinational from the current inputs; FORWARDING_EN selects the load-use-only hazard term.
module id2exe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int WAIT_W       = 8,
    parameter int WAIT_TIMEOUT = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 idValid,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 twoSrc,
    input  logic [REG_IDX_W-1:0] exeDest,
    input  logic                 exeWbEn,
    input  logic                 exeMemRead,
    input  logic [REG_IDX_W-1:0] memDest,
    input  logic                 memWbEn,
    input  logic                 branchTaken,
    input  logic                 memReq,
    input  logic                 memReady,
    output logic                 freezePC,
    output logic                 freezeIF2ID,
    output logic                 flushIF2ID,
    output logic                 flushID2EXE,
    output logic                 freezeID2EXE,
    output logic                 freezeEXE2MEM,
    output logic                 memTimeout,
    output logic [CNT_W-1:0]     bubbleCount,
    output logic                 state
);

    logic              hazard;
    logic              memStall;
    logic              bubble;
    ctrl_state_t       curState;
    ctrl_state_t       nxtState;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] nxtWaitCnt;
    logic              nxtTimeout;
    logic [CNT_W-1:0]  nxtBubble;

    hazard_detect u_hazard_detect (
        .idValid    (idValid),
        .src1       (src1),
        .src2       (src2),
        .twoSrc     (twoSrc),
        .exeDest    (exeDest),
        .exeWbEn    (exeWbEn),
        .exeMemRead (exeMemRead),
        .memDest    (memDest),
        .memWbEn    (memWbEn),
        .hazard     (hazard)
    );

    assign memStall = memReq & ~memReady;
    assign bubble   = rst & ~memStall & ~branchTaken & hazard;

    // Strobes are gated by rst so they read 0 while reset is held.
    always_comb begin
        freezePC      = 1'b0;
        freezeIF2ID   = 1'b0;
        flushIF2ID    = 1'b0;
        flushID2EXE   = 1'b0;
        freezeID2EXE  = 1'b0;
        freezeEXE2MEM = 1'b0;
        if (rst) begin
            if (memStall) begin
                freezePC      = 1'b1;
                freezeIF2ID   = 1'b1;
                freezeID2EXE  = 1'b1;
                freezeEXE2MEM = 1'b1;
            end else if (branchTaken) begin
                flushIF2ID  = 1'b1;
                flushID2EXE = 1'b1;
            end else if (hazard) begin
                freezePC    = 1'b1;
                freezeIF2ID = 1'b1;
                flushID2EXE = 1'b1;
            end
        end
    end

    always_comb begin
        nxtState   = curState;
        nxtWaitCnt = waitCnt;
        nxtTimeout = memTimeout;
        nxtBubble  = bubbleCount;
        case (curState)
            ST_RUN: begin
                if (memStall) begin
                    nxtState   = ST_WAIT;
                    nxtWaitCnt = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                if (waitCnt == WAIT_W'(WAIT_TIMEOUT)) begin
                    nxtTimeout = 1'b1;
                end
                if (!memStall) begin
                    nxtState   = ST_RUN;
                    nxtWaitCnt = '0;
                end else if (waitCnt != '1) begin
                    nxtWaitCnt = waitCnt + WAIT_W'(1);
                end
            end
            default: begin
                nxtState   = ST_RUN;
                nxtWaitCnt = '0;
            end
        endcase
        if (bubble && (bubbleCount != '1)) begin
            nxtBubble = bubbleCount + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curState    <= ST_RUN;
            waitCnt     <= '0;
            memTimeout  <= 1'b0;
            bubbleCount <= '0;
        end else begin
            curState    <= nxtState;
            waitCnt     <= nxtWaitCnt;
            memTimeout  <= nxtTimeout;
            bubbleCount <= nxtBubble;
        end
    end

    assign state = curState;

endmodule

// File: tb/tb_id2exe_hazard_ctrl.sv
// Directed and random stimulus against a rule-level reference model of the hazard controller.
module tb_id2exe_hazard_ctrl;

    localparam int TB_CNT_W   = 4;
    localparam int TB_TIMEOUT = 200;
    localparam int BUBBLE_MAX = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                idValid, twoSrc, exeWbEn, exeMemRead, memWbEn;
    logic                branchTaken, memReq, memReady;
    logic [3:0]          src1, src2, exeDest, memDest;
    logic                freezePC, freezeIF2ID, flushIF2ID, flushID2EXE;
    logic                freezeID2EXE, freezeEXE2MEM, memTimeout, state;
    logic [TB_CNT_W-1:0] bubbleCount;

    int evaluated = 0;
    int failures  = 0;

    // Reference model state
    bit mInWait;
    int mWaitCycles;
    bit mTimeout;
    int mBubbles;

    id2exe_hazard_ctrl #(
        .CNT_W        (TB_CNT_W),
        .WAIT_W       (8),
        .WAIT_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .idValid       (idValid),
        .src1          (src1),
        .src2          (src2),
        .twoSrc        (twoSrc),
        .exeDest       (exeDest),
        .exeWbEn       (exeWbEn),
        .exeMemRead    (exeMemRead),
        .memDest       (memDest),
        .memWbEn       (memWbEn),
        .branchTaken   (branchTaken),
        .memReq        (memReq),
        .memReady      (memReady),
        .freezePC      (freezePC),
        .freezeIF2ID   (freezeIF2ID),
        .flushIF2ID    (flushIF2ID),
        .flushID2EXE   (flushID2EXE),
        .freezeID2EXE  (freezeID2EXE),
        .freezeEXE2MEM (freezeEXE2MEM),
        .memTimeout    (memTimeout),
        .bubbleCount   (bubbleCount),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Set of registers still being written by instructions ahead of ID.
    function automatic bit modelHazard();
        int dests[$];
        int srcs[$];
        if (!idValid) return 1'b0;
`ifdef FORWARDING_EN
        if (exeWbEn && exeMemRead) dests.push_back(int'(exeDest));
`else
        if (exeWbEn) dests.push_back(int'(exeDest));
        if (memWbEn) dests.push_back(int'(memDest));
`endif
        srcs.push_back(int'(src1));
        if (twoSrc) srcs.push_back(int'(src2));
        foreach (srcs[i])
            foreach (dests[j])
                if (srcs[i] == dests[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clearInputs();
        idValid = 0; twoSrc = 0; exeWbEn = 0; exeMemRead = 0; memWbEn = 0;
        branchTaken = 0; memReq = 0; memReady = 0;
        src1 = 0; src2 = 0; exeDest = 0; memDest = 0;
    endtask

    task automatic modelReset();
        mInWait = 0; mWaitCycles = 0; mTimeout = 0; mBubbles = 0;
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next falling edge.
    task automatic runCycle(input string tag);
        bit stall, br, h;
        stall = memReq && !memReady;
        br    = branchTaken;
        h     = modelHazard();
        #1;
        check({tag, ".freezePC"},      freezePC,      stall || (!br && h));
        check({tag, ".freezeIF2ID"},   freezeIF2ID,   stall || (!br && h));
        check({tag, ".flushIF2ID"},    flushIF2ID,    !stall && br);
        check({tag, ".flushID2EXE"},   flushID2EXE,   !stall && (br || h));
        check({tag, ".freezeID2EXE"},  freezeID2EXE,  stall);
        check({tag, ".freezeEXE2MEM"}, freezeEXE2MEM, stall);
        @(posedge clk);
        if (mInWait) begin
            if (mWaitCycles == TB_TIMEOUT) mTimeout = 1;
            if (!stall) begin
                mInWait = 0;
                mWaitCycles = 0;
            end else if (mWaitCycles < 255) begin
                mWaitCycles++;
            end
        end else if (stall) begin
            mInWait = 1;
            mWaitCycles = 1;
        end
        if (!stall && !br && h && mBubbles < BUBBLE_MAX) mBubbles++;
        #1;
        check({tag, ".state"},       state,       mInWait);
        check({tag, ".memTimeout"},  memTimeout,  mTimeout);
        check({tag, ".bubbleCount"}, bubbleCount, mBubbles);
        @(negedge clk);
    endtask

    initial begin
        clearInputs();
        modelReset();
        rst = 0;
        // Hazard and stall both presented during reset: strobes must still read 0.
        idValid = 1; src1 = 4'd3; exeDest = 4'd3; exeWbEn = 1; memReq = 1;
        #12;
        check("reset.state",       state,       0);
        check("reset.memTimeout",  memTimeout,  0);
        check("reset.bubbleCount", bubbleCount, 0);
        check("reset.freezePC",    freezePC,    0);
        check("reset.flushID2EXE", flushID2EXE, 0);
        check("reset.freezeEXE2MEM", freezeEXE2MEM, 0);
        @(negedge clk);
        rst = 1;
        clearInputs();
        runCycle("idle");

        // RAW on EXE
        idValid = 1; src1 = 4'd3; exeDest = 4'd3; exeWbEn = 1;
        runCycle("raw_exe");
        clearInputs();

        // Load-use on src2, then the same with a non-load producer
        idValid = 1; src2 = 4'd5; twoSrc = 1; exeDest = 4'd5; exeWbEn = 1; exeMemRead = 1; src1 = 4'd9;
        runCycle("load_use");
        exeMemRead = 0;
        runCycle("exe_nonload");
        twoSrc = 0;
        runCycle("src2_unused");
        clearInputs();

        // MEM-stage match and R0 as destination
        idValid = 1; src1 = 4'd0; memDest = 4'd0; memWbEn = 1;
        runCycle("raw_mem_r0");
        clearInputs();

        // Branch wins over hazard
        idValid = 1; src1 = 4'd7; exeDest = 4'd7; exeWbEn = 1; branchTaken = 1;
        runCycle("branch_vs_h");
        clearInputs();

        // Single-cycle access: ready together with request
        memReq = 1; memReady = 1;
        runCycle("mem_ready_now");

        // 4-cycle wait with a branch and a hazard present
        memReady = 0; branchTaken = 1; idValid = 1; src1 = 4'd2; exeDest = 4'd2; exeWbEn = 1;
        for (int i = 0; i < 4; i++) runCycle("mem_wait");
        memReady = 1;
        runCycle("mem_wait_done");
        clearInputs();
        runCycle("after_wait");

        // Timeout after a 201-cycle stall, sticky afterwards
        memReq = 1; memReady = 0;
        for (int i = 0; i < 201; i++) runCycle("timeout_wait");
        check("timeout.set", memTimeout, 1);
        memReady = 1;
        runCycle("timeout_ready");
        clearInputs();
        runCycle("timeout_sticky");

        // Asynchronous reset in the middle of a wait
        idValid = 1; src1 = 4'd1; exeDest = 4'd1; exeWbEn = 1;
        runCycle("pre_wait_bubble");
        memReq = 1; memReady = 0;
        for (int i = 0; i < 3; i++) runCycle("wait_before_rst");
        #2;
        rst = 0;
        #1;
        check("async_rst.state",         state,         0);
        check("async_rst.memTimeout",    memTimeout,    0);
        check("async_rst.bubbleCount",   bubbleCount,   0);
        check("async_rst.freezePC",      freezePC,      0);
        check("async_rst.freezeEXE2MEM", freezeEXE2MEM, 0);
        check("async_rst.flushID2EXE",   flushID2EXE,   0);
        modelReset();
        @(posedge clk);
        #1;
        check("rst_held.state", state, 0);
        @(negedge clk);
        rst = 1;
        clearInputs();
        runCycle("post_rst");

        // Random traffic, small register range for frequent matches; saturates the bubble counter
        for (int i = 0; i < 400; i++) begin
            idValid     = ($urandom_range(0, 3) != 0);
            src1        = 4'($urandom_range(0, 3));
            src2        = 4'($urandom_range(0, 3));
            twoSrc      = 1'($urandom);
            exeDest     = 4'($urandom_range(0, 3));
            exeWbEn     = 1'($urandom);
            exeMemRead  = 1'($urandom);
            memDest     = 4'($urandom_range(0, 3));
            memWbEn     = 1'($urandom);
            branchTaken = ($urandom_range(0, 4) == 0);
            memReq      = ($urandom_range(0, 2) == 0);
            memReady    = 1'($urandom);
            runCycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
